hazard_forward_ctrl: RTL and testbench

Parametrised pipeline control for the 5-stage ARM core. It combines data-hazard detection, operand-forwarding select, branch flush and a variable-latency data-memory wait-state FSM. It drives the freeze, bubble and flush controls of the IF/ID, ID/EXE and EXE/MEM pipeline registers, and the operand muxes in EXE. It also keeps a saturating stall-cycle counter for performance debug.

---
 rtl/hazard_forward_ctrl_pkg.sv | 17 +
 rtl/hazard_forward_ctrl_mem_wait.sv | 59 +++++
 rtl/hazard_forward_ctrl.sv | 106 ++++++++++
 tb/tb_hazard_forward_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/forwarding controller:
// EXE operand-select encodings and the memory wait-state FSM states.
package hazard_pkg;

   localparam logic [1:0] SEL_REG = 2'b00;
   localparam logic [1:0] SEL_MEM = 2'b01;
   localparam logic [1:0] SEL_WB  = 2'b10;

   // Wide enough for the largest supported wait (15 extra cycles).
   localparam int WAIT_CNT_W = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } wait_state_t;

endpackage

// File: rtl/hazard_forward_ctrl_mem_wait.sv
// Variable-latency data-memory wait-state FSM: holds the back end of the
// pipeline for exactly MEM_WAIT cycles per load/store reaching MEM.
module mem_wait_fsm
   import hazard_pkg::*;
#(
   parameter int MEM_WAIT = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic mem_access,
   output logic stall_back,
   output logic mem_busy
);

   localparam logic [WAIT_CNT_W-1:0] CNT_LOAD =
      WAIT_CNT_W'((MEM_WAIT > 0) ? (MEM_WAIT - 1) : 0);

   wait_state_t state, state_next;
   logic [WAIT_CNT_W-1:0] cnt, cnt_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // The first wait cycle is the IDLE cycle in which the access arrives, so
   // the counter is loaded with one less than the total wait.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      stall_back = 1'b0;
      mem_busy   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (mem_access && (MEM_WAIT > 0)) begin
               stall_back = 1'b1;
               state_next = ST_WAIT;
               cnt_next   = CNT_LOAD;
            end
         end
         ST_WAIT: begin
            mem_busy   = 1'b1;
            stall_back = (cnt != '0);
            if (cnt == '0) begin
               state_next = ST_IDLE;
            end else begin
               cnt_next = cnt - 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Pipeline control for the 5-stage core: load-use / data-hazard stalls,
// EXE operand forwarding, branch flush, memory wait and a stall counter.
module hazard_forward_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = 4,
   parameter int MEM_WAIT   = 0,
   parameter int FWD_EN     = 1,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] id_src1,
   input  logic [REG_ADDR_W-1:0] id_src2,
   input  logic                  id_two_src,
   input  logic [REG_ADDR_W-1:0] exe_src1,
   input  logic [REG_ADDR_W-1:0] exe_src2,
   input  logic [REG_ADDR_W-1:0] exe_dest,
   input  logic                  exe_wb_en,
   input  logic                  exe_mem_r_en,
   input  logic [REG_ADDR_W-1:0] mem_dest,
   input  logic                  mem_wb_en,
   input  logic [REG_ADDR_W-1:0] wb_dest,
   input  logic                  wb_wb_en,
   input  logic                  mem_access,
   input  logic                  branch_taken,
   output logic                  freeze_front,
   output logic                  bubble_id,
   output logic                  stall_back,
   output logic                  flush,
   output logic [1:0]            sel_src1,
   output logic [1:0]            sel_src2,
   output logic                  mem_busy,
   output logic [CNT_W-1:0]      stall_cycles
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic match1, match2, load_use, hz;

   mem_wait_fsm #(
      .MEM_WAIT(MEM_WAIT)
   ) u_mem_wait (
      .clk        (clk),
      .rst        (rst),
      .mem_access (mem_access),
      .stall_back (stall_back),
      .mem_busy   (mem_busy)
   );

   // With forwarding only a load in EXE cannot be bypassed in time; without
   // it any in-flight writer of an ID source forces a stall.
   always_comb begin
      match1 = ((id_src1 == exe_dest) && exe_wb_en) ||
               ((id_src1 == mem_dest) && mem_wb_en);
      match2 = id_two_src &&
               (((id_src2 == exe_dest) && exe_wb_en) ||
                ((id_src2 == mem_dest) && mem_wb_en));
      load_use = exe_mem_r_en && exe_wb_en &&
                 ((id_src1 == exe_dest) || (id_two_src && (id_src2 == exe_dest)));
      hz = (FWD_EN != 0) ? load_use : (match1 || match2);
   end

   always_comb begin
      sel_src1 = SEL_REG;
      sel_src2 = SEL_REG;
      if (FWD_EN != 0) begin
         if (mem_wb_en && (exe_src1 == mem_dest)) begin
            sel_src1 = SEL_MEM;
         end else if (wb_wb_en && (exe_src1 == wb_dest)) begin
            sel_src1 = SEL_WB;
         end
         if (mem_wb_en && (exe_src2 == mem_dest)) begin
            sel_src2 = SEL_MEM;
         end else if (wb_wb_en && (exe_src2 == wb_dest)) begin
            sel_src2 = SEL_WB;
         end
      end
   end

   // A memory wait freezes everything, so a taken branch is deferred until
   // the wait ends; otherwise a flush supersedes any hazard stall.
   always_comb begin
      freeze_front = 1'b0;
      bubble_id    = 1'b0;
      flush        = 1'b0;
      if (stall_back) begin
         freeze_front = 1'b1;
      end else if (branch_taken) begin
         flush     = 1'b1;
         bubble_id = 1'b1;
      end else if (hz) begin
         freeze_front = 1'b1;
         bubble_id    = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles <= '0;
      end else if (freeze_front && (stall_cycles != CNT_MAX)) begin
         stall_cycles <= stall_cycles + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed self-checking bench: a forwarding/3-wait-state instance and a
// pure-stall/single-cycle-memory instance with a 4-bit stall counter.
module tb_hazard_forward_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] id_src1, id_src2, exe_src1, exe_src2, exe_dest, mem_dest, wb_dest;
   logic       id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en, wb_wb_en;
   logic       mem_access, branch_taken;

   logic       a_freeze, a_bubble, a_stall, a_flush, a_busy;
   logic [1:0] a_sel1, a_sel2;
   logic [15:0] a_cnt;
   logic       b_freeze, b_bubble, b_stall, b_flush, b_busy;
   logic [1:0] b_sel1, b_sel2;
   logic [3:0] b_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   hazard_forward_ctrl #(
      .REG_ADDR_W(4), .MEM_WAIT(3), .FWD_EN(1), .CNT_W(16)
   ) dut_a (
      .clk(clk), .rst(rst),
      .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
      .exe_src1(exe_src1), .exe_src2(exe_src2), .exe_dest(exe_dest),
      .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
      .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
      .wb_dest(wb_dest), .wb_wb_en(wb_wb_en),
      .mem_access(mem_access), .branch_taken(branch_taken),
      .freeze_front(a_freeze), .bubble_id(a_bubble), .stall_back(a_stall),
      .flush(a_flush), .sel_src1(a_sel1), .sel_src2(a_sel2),
      .mem_busy(a_busy), .stall_cycles(a_cnt)
   );

   hazard_forward_ctrl #(
      .REG_ADDR_W(4), .MEM_WAIT(0), .FWD_EN(0), .CNT_W(4)
   ) dut_b (
      .clk(clk), .rst(rst),
      .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
      .exe_src1(exe_src1), .exe_src2(exe_src2), .exe_dest(exe_dest),
      .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
      .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
      .wb_dest(wb_dest), .wb_wb_en(wb_wb_en),
      .mem_access(mem_access), .branch_taken(branch_taken),
      .freeze_front(b_freeze), .bubble_id(b_bubble), .stall_back(b_stall),
      .flush(b_flush), .sel_src1(b_sel1), .sel_src2(b_sel2),
      .mem_busy(b_busy), .stall_cycles(b_cnt)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus();
      id_src1 = 0; id_src2 = 0; id_two_src = 0;
      exe_src1 = 0; exe_src2 = 0; exe_dest = 0;
      exe_wb_en = 0; exe_mem_r_en = 0;
      mem_dest = 0; mem_wb_en = 0; wb_dest = 0; wb_wb_en = 0;
      mem_access = 0; branch_taken = 0;
   endtask

   // Advance one cycle; inputs are then changed 1ns after the edge.
   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst = 1'b1;
      nextCycle();
      rst = 1'b0;
   endtask

   logic exp_stall [8] = '{1, 1, 1, 0, 1, 1, 1, 0};
   logic exp_busy  [8] = '{0, 1, 1, 1, 0, 1, 1, 1};

   initial begin
      applyStimulus();
      doReset();
      #1;
      checkOutput("rst_freeze", a_freeze, 0);
      checkOutput("rst_bubble", a_bubble, 0);
      checkOutput("rst_stall", a_stall, 0);
      checkOutput("rst_flush", a_flush, 0);
      checkOutput("rst_sel", {a_sel1, a_sel2}, 0);
      checkOutput("rst_busy", a_busy, 0);
      checkOutput("rst_cnt_a", a_cnt, 0);
      checkOutput("rst_cnt_b", b_cnt, 0);

      // Load-use on either source.
      exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 3;
      id_two_src = 1; id_src2 = 3; #1;
      checkOutput("lu_src2", a_freeze, 1);
      id_two_src = 0; #1;
      checkOutput("lu_src2_unused", a_freeze, 0);
      id_src1 = 3; #1;
      checkOutput("lu_freeze", a_freeze, 1);
      checkOutput("lu_bubble", a_bubble, 1);
      checkOutput("lu_flush", a_flush, 0);
      checkOutput("lu_cnt_before", a_cnt, 0);
      nextCycle();
      exe_mem_r_en = 0; #1;
      checkOutput("lu_cnt_after", a_cnt, 1);
      checkOutput("alu_no_stall_fwd", a_freeze, 0);
      checkOutput("alu_stall_pure", b_freeze, 1);

      // ALU forwarding: MEM wins over WB.
      applyStimulus();
      doReset();
      exe_src1 = 5; exe_src2 = 5; mem_dest = 5; mem_wb_en = 1;
      wb_dest = 5; wb_wb_en = 1; #1;
      checkOutput("fwd_mem", a_sel1, 2'b01);
      checkOutput("fwd_pure_sel", b_sel1, 2'b00);
      checkOutput("fwd_no_stall", a_freeze, 0);
      mem_wb_en = 0; #1;
      checkOutput("fwd_wb1", a_sel1, 2'b10);
      checkOutput("fwd_wb2", a_sel2, 2'b10);
      wb_wb_en = 0; #1;
      checkOutput("fwd_none", a_sel1, 2'b00);

      // Pure-stall mode on the second source.
      applyStimulus();
      id_two_src = 1; id_src2 = 7; mem_dest = 7; mem_wb_en = 1; exe_src2 = 7; #1;
      checkOutput("ps_freeze", b_freeze, 1);
      checkOutput("ps_bubble", b_bubble, 1);
      checkOutput("ps_sel2", b_sel2, 2'b00);
      checkOutput("ps_fwd_freeze", a_freeze, 0);
      checkOutput("ps_fwd_sel2", a_sel2, 2'b01);
      id_two_src = 0; #1;
      checkOutput("ps_one_src", b_freeze, 0);

      // Memory wait with back-to-back accesses.
      applyStimulus();
      doReset();
      mem_access = 1;
      for (int c = 0; c < 8; c++) begin
         #1;
         checkOutput($sformatf("mw_stall_%0d", c), a_stall, exp_stall[c]);
         checkOutput($sformatf("mw_busy_%0d", c), a_busy, exp_busy[c]);
         checkOutput($sformatf("mw_nowait_%0d", c), b_stall | b_busy, 0);
         nextCycle();
      end
      mem_access = 0; #1;
      checkOutput("mw_cnt", a_cnt, 6);

      // Branch held off by the wait, then flush once.
      applyStimulus();
      doReset();
      mem_access = 1; branch_taken = 1;
      for (int c = 0; c < 3; c++) begin
         #1;
         checkOutput($sformatf("bw_flush_%0d", c), a_flush, 0);
         checkOutput($sformatf("bw_freeze_%0d", c), a_freeze, 1);
         checkOutput($sformatf("bw_bubble_%0d", c), a_bubble, 0);
         nextCycle();
      end
      #1;
      checkOutput("bw_flush_end", a_flush, 1);
      checkOutput("bw_bubble_end", a_bubble, 1);
      checkOutput("bw_freeze_end", a_freeze, 0);
      nextCycle();
      mem_access = 0;
      exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 3; id_src1 = 3; #1;
      checkOutput("bh_flush", a_flush, 1);
      checkOutput("bh_freeze", a_freeze, 0);
      checkOutput("bh_bubble", a_bubble, 1);

      // Reset in the middle of a wait.
      applyStimulus();
      doReset();
      mem_access = 1;
      nextCycle();
      checkOutput("rw_busy_pre", a_busy, 1);
      checkOutput("rw_cnt_pre", a_cnt, 1);
      rst = 1; mem_access = 0;
      nextCycle();
      rst = 0; #1;
      checkOutput("rw_busy", a_busy, 0);
      checkOutput("rw_stall", a_stall, 0);
      checkOutput("rw_cnt", a_cnt, 0);

      // Counter saturation (4-bit instance) against unsaturated 16-bit one.
      applyStimulus();
      exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 3; id_src1 = 3;
      for (int c = 0; c < 20; c++) nextCycle();
      applyStimulus(); #1;
      checkOutput("sat_b", b_cnt, 15);
      checkOutput("sat_a", a_cnt, 20);
      nextCycle();
      checkOutput("sat_hold", b_cnt, 15);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
